mem_issue_queue: RTL and testbench
==================================

MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter TAGW, default 6, the width of the destination/source tag.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, synchronous clear of all entries (pipeline flush).
REQ-005 SHALL have ports we1_ldst / we2_ldst, input, 1 each, dispatch write strobes for lanes 1 and 2.
REQ-006 SHALL have ports type1 / type2, input, 2 each, memory op type per lane: 2'b01 load, 2'b10 store; 2'b00 and 2'b11 are illegal with a strobe set.
REQ-007 SHALL have ports tag1 / tag2, input, TAGW each, source-operand tag per lane.
REQ-008 SHALL have ports rdy1 / rdy2, input, 1 each, operand already available at dispatch.
REQ-009 SHALL have port dispatch_ready, output, 1, high when at least 2 slots are free.
REQ-010 SHALL have ports wakeup_valid, input, 1, and wakeup_tag, input, TAGW, the broadcast of a produced tag.
REQ-011 SHALL have ports issue_valid, output, 1, and issue_ready, input, 1, the issue handshake.
REQ-012 SHALL have ports issue_tag, output, TAGW; issue_type, output, 2; issue_slot, output, 2, describing the selected entry.
REQ-013 SHALL have ports Type_0..Type_3, output, 2 each, the compressed per-slot type (slot 0 oldest; 2'b00 when the slot is empty), which feed the indetermination matrix.
REQ-014 SHALL have port count, output, 3, the number of valid entries (0..4).

Function
REQ-015 SHALL hold 4 entries, each {valid, type[1:0], tag, ready}, compressed: valid entries always occupy slots 0..count-1 in age order, slot 0 oldest.
REQ-016 SHALL accept a dispatch lane only when its strobe is high and dispatch_ready is high; strobes while dispatch_ready is low SHALL be ignored.
REQ-017 SHALL write accepted lanes into the lowest free slots after this cycle's compaction; lane 1 older than lane 2; a lone we2_ldst takes the first free slot.
REQ-018 SHALL compute dispatch_ready from the registered count only (count <= 2), never from same-cycle issue.
REQ-019 SHALL, on wakeup_valid, set ready on every valid entry whose tag equals wakeup_tag, at the next edge.
REQ-020 SHALL write an entry ready if its rdy input is high or wakeup_valid with wakeup_tag equal to its tag occurs in the dispatch cycle.
REQ-021 SHALL select combinationally from registered state: a store is eligible only in slot 0 and ready; a load is eligible if ready and no older valid store exists; issue the lowest-slot eligible entry.
REQ-022 SHALL drive issue_valid high whenever an eligible entry exists; issue_tag/issue_type/issue_slot SHALL be zero when issue_valid is low.
REQ-023 SHALL remove the selected entry when issue_valid && issue_ready; entries above it shift down one slot at the same edge, keeping order.
REQ-024 SHALL hold the selection stable while issue_valid && !issue_ready unless a wakeup makes an older entry eligible.
REQ-025 SHALL give a dispatched entry a minimum 1-cycle dispatch-to-issue latency; it is never issued in its dispatch cycle.
REQ-026 SHALL handle issue, dispatch and wakeup in the same cycle: removal first, then wakeup on surviving entries, then dispatch writes.
REQ-027 SHALL drive Type_n and count directly from registers (no combinational path from inputs).
REQ-028 SHALL, on flush, clear all valid bits at the next edge and ignore same-cycle dispatch and issue handshakes.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear all entries: count=0, Type_0..Type_3=2'b00, dispatch_ready=1, issue_valid=0, issue outputs zero.
REQ-030 SHALL give rst priority over flush, dispatch, wakeup and issue; a reset mid-handshake drops the in-flight entry.

Verification
REQ-031 SHALL pass: reset, then dual dispatch load(tag 3, rdy 1) + store(tag 5, rdy 0) -> next cycle count=2, Type_0=01, Type_1=10, issue_valid=1, issue_slot=0, issue_tag=3.
REQ-032 SHALL pass: slots {store tag 5 not ready, load tag 7 ready} -> issue_valid=0; wakeup tag 5 -> next cycle issue_valid=1, issue_type=10, issue_slot=0.
REQ-033 SHALL pass: 3 valid entries, we1_ldst asserted -> dispatch_ready=0, write ignored, count stays 3.
REQ-034 SHALL pass: 4 loads, slot 1 ready only, issue_ready=1 -> next cycle count=3, former slots 2,3 now in slots 1,2, order kept.
REQ-035 SHALL pass: issue of slot 0, dual dispatch and wakeup of a dispatched tag in one cycle with count=2 -> next cycle count=3, new entries in slots 1,2, woken entry ready.
REQ-036 SHALL pass: flush with count=4 and issue handshake active -> next cycle count=0, all Type_n=00, no entry reported issued.

Source files
------------

// File: rtl/mem_issue_queue_if.sv
// Dispatch, wakeup, issue and status signals of the memory issue queue.
// The queue connects through the slave modport and its driver through master.
interface mem_issue_queue_if #(
    parameter int TAGW = 6
);
    logic            flush;
    logic            we1_ldst;
    logic            we2_ldst;
    logic [1:0]      type1;
    logic [1:0]      type2;
    logic [TAGW-1:0] tag1;
    logic [TAGW-1:0] tag2;
    logic            rdy1;
    logic            rdy2;
    logic            dispatch_ready;
    logic            wakeup_valid;
    logic [TAGW-1:0] wakeup_tag;
    logic            issue_valid;
    logic            issue_ready;
    logic [TAGW-1:0] issue_tag;
    logic [1:0]      issue_type;
    logic [1:0]      issue_slot;
    logic [1:0]      Type_0;
    logic [1:0]      Type_1;
    logic [1:0]      Type_2;
    logic [1:0]      Type_3;
    logic [2:0]      count;

    modport master (
        output flush, we1_ldst, we2_ldst, type1, type2, tag1, tag2, rdy1, rdy2,
        output wakeup_valid, wakeup_tag, issue_ready,
        input  dispatch_ready, issue_valid, issue_tag, issue_type, issue_slot,
        input  Type_0, Type_1, Type_2, Type_3, count
    );

    modport slave (
        input  flush, we1_ldst, we2_ldst, type1, type2, tag1, tag2, rdy1, rdy2,
        input  wakeup_valid, wakeup_tag, issue_ready,
        output dispatch_ready, issue_valid, issue_tag, issue_type, issue_slot,
        output Type_0, Type_1, Type_2, Type_3, count
    );
endinterface

// File: rtl/mem_issue_queue.sv
// Four-entry compressed, age-ordered load/store issue queue with tag wakeup.
// Stores issue only from the oldest slot; loads may not pass an older store.
module mem_issue_queue #(
    parameter int TAGW = 6
) (
    input logic               clk,
    input logic               rst,
    mem_issue_queue_if.slave  q
);
    localparam int N = 4;
    localparam logic [1:0] TyLoad  = 2'b01;
    localparam logic [1:0] TyStore = 2'b10;

    logic [N-1:0]    valid_q, valid_d;
    logic [N-1:0]    rdy_q, rdy_d;
    logic [1:0]      type_q [N];
    logic [1:0]      type_d [N];
    logic [TAGW-1:0] tag_q [N];
    logic [TAGW-1:0] tag_d [N];
    logic [2:0]      count_q, count_d;

    logic [N-1:0] elig;
    logic         older_store;
    logic         sel_vld;
    logic [1:0]   sel;

    // Selection looks only at registered state, so new entries wait a cycle.
    always_comb begin
        elig        = '0;
        older_store = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid_q[i] && rdy_q[i]) begin
                if (type_q[i] == TyStore) elig[i] = (i == 0);
                else if (type_q[i] == TyLoad) elig[i] = !older_store;
            end
            if (valid_q[i] && type_q[i] == TyStore) older_store = 1'b1;
        end
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i]) sel = 2'(i);
        end
        sel_vld = |elig;
    end

    logic       fire;
    logic       acc1, acc2;
    logic [2:0] cnt;
    logic [2:0] src;
    logic [2:0] pos1, pos2;

    always_comb begin
        fire    = sel_vld && q.issue_ready && !q.flush;
        acc1    = q.we1_ldst && q.dispatch_ready && !q.flush;
        acc2    = q.we2_ldst && q.dispatch_ready && !q.flush;
        cnt     = count_q - {2'b00, fire};
        pos1    = cnt;
        pos2    = cnt + {2'b00, acc1};
        count_d = pos2 + {2'b00, acc2};
        src     = '0;
        valid_d = '0;
        rdy_d   = '0;
        for (int i = 0; i < N; i++) begin
            type_d[i] = '0;
            tag_d[i]  = '0;
        end

        for (int i = 0; i < N; i++) begin
            // Removal: every slot at or above the issued one pulls from its neighbour.
            src = 3'(i) + {2'b00, (fire && 2'(i) >= sel)};
            if (src < 3'(N)) begin
                valid_d[i] = valid_q[src[1:0]];
                rdy_d[i]   = rdy_q[src[1:0]];
                type_d[i]  = type_q[src[1:0]];
                tag_d[i]   = tag_q[src[1:0]];
            end
            if (valid_d[i] && q.wakeup_valid && tag_d[i] == q.wakeup_tag) rdy_d[i] = 1'b1;
            if (acc1 && 3'(i) == pos1) begin
                valid_d[i] = 1'b1;
                type_d[i]  = q.type1;
                tag_d[i]   = q.tag1;
                rdy_d[i]   = q.rdy1 || (q.wakeup_valid && q.wakeup_tag == q.tag1);
            end
            if (acc2 && 3'(i) == pos2) begin
                valid_d[i] = 1'b1;
                type_d[i]  = q.type2;
                tag_d[i]   = q.tag2;
                rdy_d[i]   = q.rdy2 || (q.wakeup_valid && q.wakeup_tag == q.tag2);
            end
        end

        if (q.flush) begin
            count_d = '0;
            valid_d = '0;
            rdy_d   = '0;
            for (int i = 0; i < N; i++) begin
                type_d[i] = '0;
                tag_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rdy_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) begin
                type_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
            count_q <= count_d;
            type_q  <= type_d;
            tag_q   <= tag_d;
        end
    end

    assign q.dispatch_ready = (count_q <= 3'd2);
    assign q.count          = count_q;
    assign q.Type_0         = type_q[0];
    assign q.Type_1         = type_q[1];
    assign q.Type_2         = type_q[2];
    assign q.Type_3         = type_q[3];
    assign q.issue_valid    = sel_vld;
    assign q.issue_slot     = sel_vld ? sel : 2'b00;
    assign q.issue_type     = sel_vld ? type_q[sel] : 2'b00;
    assign q.issue_tag      = sel_vld ? tag_q[sel] : '0;
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue with hand-computed expectations.
module tb_mem_issue_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_issue_queue_if #(.TAGW(6)) bus ();

    mem_issue_queue #(.TAGW(6)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.we1_ldst     = 1'b0;
        bus.we2_ldst     = 1'b0;
        bus.wakeup_valid = 1'b0;
        bus.issue_ready  = 1'b0;
    endtask

    task automatic set_lanes(input logic w1, input logic [1:0] t1, input logic [5:0] g1,
                             input logic r1, input logic w2, input logic [1:0] t2,
                             input logic [5:0] g2, input logic r2);
        bus.we1_ldst = w1; bus.type1 = t1; bus.tag1 = g1; bus.rdy1 = r1;
        bus.we2_ldst = w2; bus.type2 = t2; bus.tag2 = g2; bus.rdy2 = r2;
    endtask

    task automatic wake(input logic [5:0] t);
        bus.wakeup_valid = 1'b1;
        bus.wakeup_tag   = t;
        step();
        bus.wakeup_valid = 1'b0;
    endtask

    initial begin
        idle();
        set_lanes(0, 2'b00, 0, 0, 0, 2'b00, 0, 0);
        bus.wakeup_tag = '0;
        step(); step();
        rst = 1'b0;
        check("rst_count", bus.count, 0);
        check("rst_type0", bus.Type_0, 0);
        check("rst_dready", bus.dispatch_ready, 1);
        check("rst_ivalid", bus.issue_valid, 0);
        check("rst_itag", bus.issue_tag, 0);
        check("rst_islot", bus.issue_slot, 0);

        // Dual dispatch: load tag 3 ready, store tag 5 not ready.
        set_lanes(1, 2'b01, 3, 1, 1, 2'b10, 5, 0);
        #1 check("disp_cycle_noissue", bus.issue_valid, 0);
        step(); idle();
        check("d1_count", bus.count, 2);
        check("d1_type0", bus.Type_0, 2'b01);
        check("d1_type1", bus.Type_1, 2'b10);
        check("d1_ivalid", bus.issue_valid, 1);
        check("d1_islot", bus.issue_slot, 0);
        check("d1_itag", bus.issue_tag, 3);
        check("d1_itype", bus.issue_type, 2'b01);
        bus.issue_ready = 1'b1; step(); idle();
        check("d1_pop_count", bus.count, 1);
        check("d1_pop_type0", bus.Type_0, 2'b10);
        check("d1_pop_type1", bus.Type_1, 2'b00);
        check("d1_pop_ivalid", bus.issue_valid, 0);

        // Lone lane-2 load behind an unready store; store wakeup.
        set_lanes(0, 2'b00, 0, 0, 1, 2'b01, 7, 1);
        step(); idle();
        check("st_count", bus.count, 2);
        check("st_type1", bus.Type_1, 2'b01);
        check("st_blocked", bus.issue_valid, 0);
        check("st_blocked_tag", bus.issue_tag, 0);
        wake(5);
        check("st_wake_ivalid", bus.issue_valid, 1);
        check("st_wake_itype", bus.issue_type, 2'b10);
        check("st_wake_islot", bus.issue_slot, 0);
        check("st_wake_itag", bus.issue_tag, 5);
        step();
        check("st_hold_itag", bus.issue_tag, 5);
        bus.issue_ready = 1'b1; step();
        check("st_pop_count", bus.count, 1);
        check("st_pop_itag", bus.issue_tag, 7);
        check("st_pop_islot", bus.issue_slot, 0);
        step(); idle();
        check("st_empty", bus.count, 0);

        // Full-threshold: 3 entries blocks dispatch.
        set_lanes(1, 2'b01, 1, 0, 1, 2'b01, 2, 0);
        step();
        set_lanes(1, 2'b01, 3, 0, 0, 2'b00, 0, 0);
        step();
        check("thr_count3", bus.count, 3);
        check("thr_dready", bus.dispatch_ready, 0);
        set_lanes(1, 2'b01, 4, 1, 0, 2'b00, 0, 0);
        step(); idle();
        check("thr_ignored_count", bus.count, 3);
        check("thr_ignored_type3", bus.Type_3, 0);
        check("thr_ivalid", bus.issue_valid, 0);
        bus.flush = 1'b1; step(); idle();
        check("thr_flush_count", bus.count, 0);

        // Four loads, only slot 1 ready; issue compacts upper entries.
        set_lanes(1, 2'b01, 10, 0, 1, 2'b01, 11, 1);
        step();
        set_lanes(1, 2'b01, 12, 0, 1, 2'b01, 13, 0);
        step(); idle();
        check("q4_count", bus.count, 4);
        check("q4_dready", bus.dispatch_ready, 0);
        check("q4_islot", bus.issue_slot, 1);
        check("q4_itag", bus.issue_tag, 11);
        bus.issue_ready = 1'b1; step(); idle();
        check("q4_pop_count", bus.count, 3);
        check("q4_pop_type3", bus.Type_3, 0);
        check("q4_pop_ivalid", bus.issue_valid, 0);
        wake(13);
        check("q4_w13_slot", bus.issue_slot, 2);
        check("q4_w13_tag", bus.issue_tag, 13);
        wake(12);
        check("q4_w12_slot", bus.issue_slot, 1);
        check("q4_w12_tag", bus.issue_tag, 12);
        wake(10);
        check("q4_w10_slot", bus.issue_slot, 0);
        check("q4_w10_tag", bus.issue_tag, 10);

        // Refill to four, then flush while issuing and dispatching.
        bus.issue_ready = 1'b1; step(); idle();
        set_lanes(1, 2'b01, 20, 0, 1, 2'b01, 21, 0);
        step(); idle();
        check("fl_count4", bus.count, 4);
        check("fl_itag", bus.issue_tag, 12);
        bus.flush = 1'b1; bus.issue_ready = 1'b1;
        set_lanes(1, 2'b01, 22, 1, 0, 2'b00, 0, 0);
        step(); idle();
        check("fl_count", bus.count, 0);
        check("fl_type0", bus.Type_0, 0);
        check("fl_type3", bus.Type_3, 0);
        check("fl_ivalid", bus.issue_valid, 0);
        check("fl_dready", bus.dispatch_ready, 1);

        // Issue + dual dispatch + wakeup of a dispatched tag in one cycle.
        set_lanes(1, 2'b01, 30, 1, 1, 2'b01, 31, 0);
        step(); idle();
        check("mix_itag0", bus.issue_tag, 30);
        bus.issue_ready = 1'b1;
        bus.wakeup_valid = 1'b1; bus.wakeup_tag = 33;
        set_lanes(1, 2'b01, 32, 0, 1, 2'b01, 33, 0);
        step(); idle();
        check("mix_count", bus.count, 3);
        check("mix_type2", bus.Type_2, 2'b01);
        check("mix_islot", bus.issue_slot, 2);
        check("mix_itag", bus.issue_tag, 33);
        wake(32);
        check("mix_w32_slot", bus.issue_slot, 1);
        check("mix_w32_tag", bus.issue_tag, 32);

        // Reset during an active handshake drops everything.
        rst = 1'b1; bus.issue_ready = 1'b1;
        step();
        rst = 1'b0; idle();
        check("rst2_count", bus.count, 0);
        check("rst2_ivalid", bus.issue_valid, 0);
        check("rst2_type0", bus.Type_0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
